// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and the round-robin arbiter that fronts it.
package alu_pkg;
    localparam int ALU_SEL_W = 2;
    localparam int ALU_W     = 4;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                              input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction
endpackage

// File: rtl/alu.sv
// 4-bit ALU: sel 00 add, 01 sub (carry = borrow), 10 and, 11 or.
module alu
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0]     a,
    input  logic [ALU_W-1:0]     b,
    input  logic [ALU_SEL_W-1:0] sel,
    output logic [ALU_W-1:0]     y,
    output logic [ALU_W:0]       full_result,
    output logic                 zero,
    output logic                 negative,
    output logic                 carry,
    output logic                 overflow
);
    logic [ALU_W:0] w_full;

    always_comb begin
        w_full   = '0;
        overflow = 1'b0;
        case (sel)
            2'b00: begin
                w_full   = {1'b0, a} + {1'b0, b};
                overflow = (a[ALU_W-1] == b[ALU_W-1]) && (w_full[ALU_W-1] != a[ALU_W-1]);
            end
            2'b01: begin
                w_full   = {1'b0, a} - {1'b0, b};
                overflow = (a[ALU_W-1] != b[ALU_W-1]) && (w_full[ALU_W-1] != a[ALU_W-1]);
            end
            2'b10:   w_full = {1'b0, a & b};
            default: w_full = {1'b0, a | b};
        endcase
    end

    assign y           = w_full[ALU_W-1:0];
    assign full_result = w_full;
    assign carry       = w_full[ALU_W];
    assign zero        = (w_full[ALU_W-1:0] == '0);
    assign negative    = w_full[ALU_W-1];
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after i_last, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);
    int w_c;

    always_comb begin
        w_c     = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Scanning from last+1 puts the previous winner at the very end of the order.
        for (int k = 1; k <= NREQ; k++) begin
            w_c = (int'(i_last) + k) % NREQ;
            if (!o_any && i_req[w_c]) begin
                o_any        = 1'b1;
                o_grant[w_c] = 1'b1;
                o_idx        = IDW'(w_c);
            end
        end
    end
endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one ALU among NREQ requesters; one operation in flight.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [ALU_W*NREQ-1:0]     req_a,
    input  logic [ALU_W*NREQ-1:0]     req_b,
    input  logic [ALU_SEL_W*NREQ-1:0] req_sel,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [IDW-1:0]            rsp_id,
    output logic [ALU_W-1:0]          rsp_y,
    output logic [ALU_W:0]            rsp_full,
    output logic [3:0]                rsp_flags,
    output logic                      busy
);
    arb_state_t           r_state;
    logic [IDW-1:0]       r_last;
    logic [IDW-1:0]       r_gid;
    logic [ALU_W-1:0]     r_a;
    logic [ALU_W-1:0]     r_b;
    logic [ALU_SEL_W-1:0] r_sel;

    logic [NREQ-1:0]      w_grant;
    logic [IDW-1:0]       w_idx;
    logic                 w_any;
    logic                 w_accept;
    logic [ALU_W-1:0]     w_y;
    logic [ALU_W:0]       w_full;
    logic                 w_zero;
    logic                 w_neg;
    logic                 w_carry;
    logic                 w_ovf;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .i_req   (req_valid),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_accept  = (r_state == IDLE) && w_any;
    assign req_ready = (r_state == IDLE && !rst) ? w_grant : '0;
    assign busy      = (r_state != IDLE);

    // Operand registers are pure data, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a   <= req_a[w_idx*ALU_W +: ALU_W];
            r_b   <= req_b[w_idx*ALU_W +: ALU_W];
            r_sel <= req_sel[w_idx*ALU_SEL_W +: ALU_SEL_W];
        end
    end

    alu u_alu (
        .a           (r_a),
        .b           (r_b),
        .sel         (r_sel),
        .y           (w_y),
        .full_result (w_full),
        .zero        (w_zero),
        .negative    (w_neg),
        .carry       (w_carry),
        .overflow    (w_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_last    <= IDW'(NREQ - 1);
            r_gid     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_y     <= '0;
            rsp_full  <= '0;
            rsp_flags <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_last  <= w_idx;
                        r_gid   <= w_idx;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= w_y;
                    rsp_full  <= w_full;
                    rsp_flags <= pack_flags(w_zero, w_neg, w_carry, w_ovf);
                    rsp_id    <= r_gid;
                    rsp_valid <= 1'b1;
                    r_state   <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: vector table plus multi-cycle corner sequences.
module tb_alu_rr_arbiter;
    logic clk = 1'b0;
    logic rst;

    logic [1:0]  v2;
    logic [7:0]  a2, b2;
    logic [3:0]  s2;
    logic [1:0]  rdy2;
    logic        rv2, rr2, busy2;
    logic [1:0]  id2;
    logic [3:0]  y2, fl2;
    logic [4:0]  f2;

    logic [3:0]  v4;
    logic [15:0] a4, b4;
    logic [7:0]  s4;
    logic [3:0]  rdy4;
    logic        rv4, rr4, busy4;
    logic [1:0]  id4;
    logic [3:0]  y4, fl4;
    logic [4:0]  f4;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        int         r;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] sel;
        logic [3:0] y;
        logic [4:0] full;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    alu_rr_arbiter #(.NREQ(2), .IDW(2)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_a(a2), .req_b(b2), .req_sel(s2),
        .req_ready(rdy2), .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(id2),
        .rsp_y(y2), .rsp_full(f2), .rsp_flags(fl2), .busy(busy2)
    );

    alu_rr_arbiter #(.NREQ(4), .IDW(2)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_a(a4), .req_b(b4), .req_sel(s4),
        .req_ready(rdy4), .rsp_valid(rv4), .rsp_ready(rr4), .rsp_id(id4),
        .rsp_y(y4), .rsp_full(f4), .rsp_flags(fl4), .busy(busy4)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive2(input int r, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] sel);
        v2[r]          = 1'b1;
        a2[4*r +: 4]   = a;
        b2[4*r +: 4]   = b;
        s2[2*r +: 2]   = sel;
    endtask

    // Enter at a negedge in IDLE; leaves at the negedge after the response is consumed.
    task automatic run_vec(input vec_t t);
        v2 = '0;
        drive2(t.r, t.a, t.b, t.sel);
        #1 chk("vec_ready", 32'(rdy2), 32'(1 << t.r));
        @(negedge clk);
        chk("vec_exec_ready", 32'(rdy2), 0);
        chk("vec_exec_busy", 32'(busy2), 1);
        chk("vec_exec_rv", 32'(rv2), 0);
        v2 = '0;
        a2 = ~a2;
        b2 = ~b2;
        s2 = ~s2;
        @(negedge clk);
        chk("vec_rv", 32'(rv2), 1);
        chk("vec_id", 32'(id2), 32'(t.r));
        chk("vec_y", 32'(y2), 32'(t.y));
        chk("vec_full", 32'(f2), 32'(t.full));
        chk("vec_flags", 32'(fl2), 32'(t.fl));
        @(negedge clk);
        chk("vec_done_rv", 32'(rv2), 0);
        chk("vec_done_busy", 32'(busy2), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 4'hF, 4'h1, 2'b00, 4'h0, 5'h10, 4'hA};
        tbl[1] = '{1, 4'h7, 4'h1, 2'b00, 4'h8, 5'h08, 4'h5};
        tbl[2] = '{0, 4'h5, 4'h3, 2'b01, 4'h2, 5'h02, 4'h0};
        tbl[3] = '{1, 4'h3, 4'h5, 2'b01, 4'hE, 5'h1E, 4'h6};
        tbl[4] = '{0, 4'h8, 4'h1, 2'b01, 4'h7, 5'h07, 4'h1};
        tbl[5] = '{1, 4'hC, 4'hA, 2'b10, 4'h8, 5'h08, 4'h4};
        tbl[6] = '{0, 4'h0, 4'h0, 2'b11, 4'h0, 5'h00, 4'h8};
        tbl[7] = '{1, 4'h8, 4'h8, 2'b00, 4'h0, 5'h10, 4'hB};

        rst = 1'b1;
        v2 = '0; a2 = '0; b2 = '0; s2 = '0; rr2 = 1'b1;
        v4 = '0; a4 = '0; b4 = '0; s4 = '0; rr4 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rv", 32'(rv2), 0);
        chk("rst_id", 32'(id2), 0);
        chk("rst_y", 32'(y2), 0);
        chk("rst_full", 32'(f2), 0);
        chk("rst_flags", 32'(fl2), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_ready", 32'(rdy2), 0);
        chk("rst_rv4", 32'(rv4), 0);
        chk("rst_busy4", 32'(busy4), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i]);

        // Both requesters held valid: grants alternate starting with requester 0.
        do_reset();
        v2 = '0;
        drive2(0, 4'h1, 4'h1, 2'b00);
        drive2(1, 4'h2, 4'h1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            #1 chk("rr_grant", 32'(rdy2), 32'(1 << (k % 2)));
            chk("rr_onehot", 32'($countones(rdy2)), 1);
            @(negedge clk);
            chk("rr_exec_ready", 32'(rdy2), 0);
            @(negedge clk);
            chk("rr_id", 32'(id2), 32'(k % 2));
            chk("rr_y", 32'(y2), (k % 2 == 1) ? 32'h3 : 32'h2);
            @(negedge clk);
        end
        v2 = '0;

        // Backpressure, plus a one-cycle req0 pulse during RESP that must be ignored.
        rr2 = 1'b0;
        drive2(1, 4'h7, 4'h1, 2'b00);
        @(negedge clk);
        v2 = '0;
        @(negedge clk);
        chk("bp_rv0", 32'(rv2), 1);
        for (int i = 0; i < 5; i++) begin
            v2 = (i == 0) ? 2'b01 : 2'b00;
            a2[3:0] = 4'h3;
            #1 chk("bp_ready", 32'(rdy2), 0);
            @(negedge clk);
            chk("bp_rv", 32'(rv2), 1);
            chk("bp_y", 32'(y2), 32'h8);
            chk("bp_flags", 32'(fl2), 32'h5);
            chk("bp_id", 32'(id2), 1);
        end
        v2 = '0;
        rr2 = 1'b1;
        @(negedge clk);
        chk("bp_done_rv", 32'(rv2), 0);
        chk("bp_hold_y", 32'(y2), 32'h8);
        chk("bp_hold_id", 32'(id2), 1);
        repeat (2) @(negedge clk);
        chk("pulse_no_rsp", 32'(rv2), 0);
        chk("pulse_no_busy", 32'(busy2), 0);

        // Reset during EXEC: no response, pointer back to NREQ-1.
        v2 = '0;
        drive2(0, 4'h3, 4'h4, 2'b00);
        @(negedge clk);
        v2 = '0;
        chk("rx_busy_before", 32'(busy2), 1);
        rst = 1'b1;
        #1 chk("rx_busy_async", 32'(busy2), 0);
        chk("rx_rv_async", 32'(rv2), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rx_no_rsp", 32'(rv2), 0);
        v2 = 2'b11;
        #1 chk("rx_first_grant", 32'(rdy2), 32'h1);
        v2 = '0;

        // Reset during RESP clears the response registers immediately.
        rr2 = 1'b0;
        drive2(1, 4'h7, 4'h1, 2'b00);
        @(negedge clk);
        v2 = '0;
        @(negedge clk);
        chk("rr_resp_rv", 32'(rv2), 1);
        rst = 1'b1;
        #1 chk("rr_rst_rv", 32'(rv2), 0);
        chk("rr_rst_y", 32'(y2), 0);
        chk("rr_rst_full", 32'(f2), 0);
        chk("rr_rst_flags", 32'(fl2), 0);
        chk("rr_rst_id", 32'(id2), 0);
        chk("rr_rst_busy", 32'(busy2), 0);
        @(negedge clk);
        rst = 1'b0;
        rr2 = 1'b1;

        // Four requesters, only requester 3 active.
        v4 = 4'b1000;
        a4[15:12] = 4'h2;
        b4[15:12] = 4'h3;
        s4[7:6]   = 2'b00;
        #1 chk("n4_ready", 32'(rdy4), 32'h8);
        @(negedge clk);
        v4 = '0;
        @(negedge clk);
        chk("n4_rv", 32'(rv4), 1);
        chk("n4_id", 32'(id4), 3);
        chk("n4_y", 32'(y4), 32'h5);
        chk("n4_full", 32'(f4), 32'h05);
        chk("n4_flags", 32'(fl4), 32'h0);
        @(negedge clk);
        chk("n4_done", 32'(rv4), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one instance of the team's 4-bit `alu` (a, b, sel -> y, full_result, zero, negative, carry, overflow) between NREQ requesters.
- Round-robin arbitration, valid/ready handshake on each requester, and a registered response channel with backpressure.
- Sits between the datapath clients and the shared ALU; exactly one operation is in flight at a time.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the requester-ID field; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  per-requester request valid.
- req_a  input  4*NREQ  operand a; requester i occupies bits [4i+3:4i].
- req_b  input  4*NREQ  operand b, packed the same way.
- req_sel  input  2*NREQ  ALU select; requester i occupies bits [2i+1:2i].
- req_ready  output  NREQ  one-hot accept strobe.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  downstream accepts the response.
- rsp_id  output  IDW  index of the requester that owns this response.
- rsp_y  output  4  ALU result.
- rsp_full  output  5  ALU full_result, i.e. {carry, y}.
- rsp_flags  output  4  {zero, negative, carry, overflow}.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset state:
  - state=IDLE, last_grant=NREQ-1, so requester 0 wins first.
  - rsp_valid=0, rsp_id=0, rsp_y=0, rsp_full=0, rsp_flags=0, busy=0, req_ready=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is set, the grant goes to the first set bit scanning last_grant+1, last_grant+2, ... modulo NREQ.
  - req_ready[g] is asserted combinationally in the same cycle; the handshake completes when valid && ready.
  - On that edge: capture a, b and sel into the operand registers, set last_grant=g, record grant_id=g, go to EXEC.
  - If no request is valid, stay in IDLE with req_ready=0.
- EXEC:
  - The alu is driven only from the operand registers, never directly from requester ports.
  - On the edge: register the ALU outputs into rsp_y, rsp_full and rsp_flags; set rsp_id=grant_id and rsp_valid=1; go to RESP.
- RESP:
  - Response registers hold stable while rsp_valid=1 && rsp_ready=0.
  - On the edge where rsp_ready=1: clear rsp_valid and go to IDLE.
  - rsp_y, rsp_full, rsp_flags and rsp_id keep their last values after the response is consumed.
- Latency and throughput:
  - Accept edge to rsp_valid is 1 cycle.
  - With no backpressure, one operation completes every 3 cycles.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and operands stable until accepted; dropping valid before acceptance withdraws the request with no side effects.
- Fairness: a requester that holds valid is granted within NREQ arbitration rounds. A requester that was just granted has lowest priority on the next round.
- Multiple simultaneous requests: exactly one grant per round; req_ready is never multi-hot.
- Arithmetic and flags: pure pass-through of alu. No widening or saturation inside this block.
- Reset asserted mid-operation: the in-flight op is discarded, no response is emitted, the round-robin pointer returns to NREQ-1 and all outputs return to their reset values immediately (asynchronous).
- Out-of-range bits of grant_id are never produced; rsp_id is always < NREQ.

Decomposition:
- Shared package alu_pkg:
  - sel width ALU_SEL_W=2.
  - data width ALU_W=4.
  - flag bit indices FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - FSM state typedef arb_state_t {IDLE, EXEC, RESP}.
- One sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: request vector, last_grant.
  - Outputs: one-hot grant, grant index, any-valid.
- The existing alu is instantiated once, unmodified.

Test Plan:
- Reset, then req0 sends a=1111, b=0001, sel=00; rsp_ready=1.
  -> req_ready[0] in the acceptance cycle.
  -> rsp_valid exactly 1 cycle later with rsp_id=0, rsp_y=0000, rsp_full=10000, rsp_flags=1010 (Z=1, N=0, C=1, V=0).
- req0 and req1 both valid continuously.
  -> Grants alternate 0,1,0,1 over 4 ops; rsp_id sequence is 0,1,0,1.
  -> Never two grants in one round.
- req1 sends 0111+0001 with sel=00 while rsp_ready is held 0 for 5 cycles.
  -> rsp_valid stays 1 with rsp_y=1000 and flags=0101 stable throughout.
  -> req_ready stays 0 throughout; one response after rsp_ready rises.
- rst asserted during EXEC.
  -> rsp_valid=0 and busy=0 asynchronously.
  -> After release, req1 and req0 both valid -> req0 is granted first.
- req0 asserts valid for 1 cycle while the arbiter is in RESP, then drops valid.
  -> No grant and no response for req0.
  -> With NREQ=4 and only req3 valid, the grant goes to 3 and rsp_id=3.
